// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: address/control sequencer for one radix-2 DIF stage.
//
// The read side sweeps butterfly index b over 0..N/2-1. For each b it issues the
// top read and then the bottom read, and it fetches the twiddle in the same
// cycle as the bottom read. The pair tags go forward to the butterfly. The
// write side turns returned tag pairs into two-cycle writes into the next stage
// RAM. A 1-deep skid buffer absorbs one early pair; a pair that arrives while
// the skid is still full is dropped and flagged as an overrun.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   start, stall                  sweep start (IDLE only), read hold
//   en_rd, rd_ptr                 data RAM read port
//   en_tw, tw_ptr                 twiddle ROM read port
//   adr_ptr1_o, adr_ptr2_o        pair tags sent to the butterfly
//   en_back_mem_o                 pulse: pair tags valid
//   busy, done_o                  sweep status
//   en_back_mem, adr_ptr1/2       returned pair from the butterfly
//   en_wr, wr_ptr1/2, wr_half     next-stage RAM write port
//   wr_done, wr_overrun           N/2 pairs written, dropped pair (sticky)
//
// Read FSM
//   state  | meaning
//   IDLE   | waiting for start
//   RD_TOP | issue top read of pair b
//   RD_BOT | issue bottom read and twiddle, publish tags
//   DONE   | one-cycle done_o, then back to IDLE
// Write FSM
//   W_IDLE | no pair in flight
//   W1     | writing first half (wr_ptr1)
//   W2     | writing second half (wr_ptr2)
module fft_stage_ctrl #(
   parameter int N     = 256,
   parameter int SIZE  = 8,
   parameter int STAGE = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stall,
   output logic            en_rd,
   output logic [SIZE-1:0] rd_ptr,
   output logic            en_tw,
   output logic [SIZE-2:0] tw_ptr,
   output logic [SIZE-1:0] adr_ptr1_o,
   output logic [SIZE-1:0] adr_ptr2_o,
   output logic            en_back_mem_o,
   output logic            busy,
   output logic            done_o,
   input  logic            en_back_mem,
   input  logic [SIZE-1:0] adr_ptr1,
   input  logic [SIZE-1:0] adr_ptr2,
   output logic            en_wr,
   output logic [SIZE-1:0] wr_ptr1,
   output logic [SIZE-1:0] wr_ptr2,
   output logic            wr_half,
   output logic            wr_done,
   output logic            wr_overrun
);

   localparam int SH = SIZE - 1 - STAGE;
   localparam logic [SIZE-1:0] S_VAL      = SIZE'(2 ** SH);
   localparam logic [SIZE-1:0] S_MASK     = SIZE'(2 ** SH - 1);
   localparam logic [SIZE-2:0] B_LAST     = (SIZE-1)'(N / 2 - 1);
   localparam logic [SIZE-1:0] PAIRS_LAST = SIZE'(N / 2 - 1);

   typedef enum logic [1:0] {IDLE, RD_TOP, RD_BOT, DONE} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W1, W2} wr_state_t;

   rd_state_t       state_q, state_d;
   logic [SIZE-2:0] b_q, b_d;
   logic            en_rd_q, en_rd_d, en_tw_q, en_tw_d, en_bem_q, en_bem_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic [SIZE-1:0] rd_ptr_q, rd_ptr_d, adr1_q, adr1_d, adr2_q, adr2_d;
   logic [SIZE-2:0] tw_ptr_q, tw_ptr_d;

   wr_state_t       wstate_q, wstate_d;
   logic            en_wr_q, en_wr_d, wr_half_q, wr_half_d;
   logic            wr_done_q, wr_done_d, ovr_q, ovr_d;
   logic [SIZE-1:0] wr_ptr1_q, wr_ptr1_d, wr_ptr2_q, wr_ptr2_d;
   logic            skid_vld_q, skid_vld_d;
   logic [SIZE-1:0] skid1_q, skid1_d, skid2_q, skid2_d;
   logic [SIZE-1:0] cnt_q, cnt_d;

   logic [SIZE-1:0] b_ext, grp, j, top, bot, tw_full;

   // Group g selects a block of 2S addresses; j is the offset inside the block.
   always_comb begin
      b_ext   = {1'b0, b_q};
      grp     = b_ext >> SH;
      j       = b_ext & S_MASK;
      top     = (grp << (SIZE - STAGE)) + j;
      bot     = top + S_VAL;
      tw_full = j << STAGE;
   end

   always_comb begin
      state_d  = state_q;
      b_d      = b_q;
      en_rd_d  = 1'b0;
      en_tw_d  = 1'b0;
      en_bem_d = 1'b0;
      done_d   = 1'b0;
      busy_d   = busy_q;
      rd_ptr_d = rd_ptr_q;
      tw_ptr_d = tw_ptr_q;
      adr1_d   = adr1_q;
      adr2_d   = adr2_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = RD_TOP;
               busy_d  = 1'b1;
            end
         end
         RD_TOP: if (!stall) begin
            en_rd_d  = 1'b1;
            rd_ptr_d = top;
            adr1_d   = top;
            state_d  = RD_BOT;
         end
         RD_BOT: if (!stall) begin
            en_rd_d  = 1'b1;
            rd_ptr_d = bot;
            adr2_d   = bot;
            en_tw_d  = 1'b1;
            tw_ptr_d = tw_full[SIZE-2:0];
            en_bem_d = 1'b1;
            if (b_q == B_LAST) begin
               state_d = DONE;
               b_d     = '0;
            end else begin
               state_d = RD_TOP;
               b_d     = b_q + 1'b1;
            end
         end
         DONE: begin
            rd_ptr_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wstate_d   = wstate_q;
      en_wr_d    = 1'b0;
      wr_half_d  = 1'b0;
      wr_done_d  = 1'b0;
      wr_ptr1_d  = wr_ptr1_q;
      wr_ptr2_d  = wr_ptr2_q;
      skid_vld_d = skid_vld_q;
      skid1_d    = skid1_q;
      skid2_d    = skid2_q;
      ovr_d      = ovr_q;
      cnt_d      = cnt_q;
      case (wstate_q)
         W_IDLE: if (en_back_mem) begin
            wstate_d  = W1;
            en_wr_d   = 1'b1;
            wr_ptr1_d = adr_ptr1;
            wr_ptr2_d = adr_ptr2;
         end
         W1: begin
            wstate_d  = W2;
            en_wr_d   = 1'b1;
            wr_half_d = 1'b1;
            if (en_back_mem) begin
               if (skid_vld_q) begin
                  ovr_d = 1'b1;
               end else begin
                  skid_vld_d = 1'b1;
                  skid1_d    = adr_ptr1;
                  skid2_d    = adr_ptr2;
               end
            end
         end
         W2: begin
            // Second half is being written this cycle, so the pair is complete.
            if (cnt_q == PAIRS_LAST) begin
               cnt_d     = '0;
               wr_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (skid_vld_q) begin
               wstate_d   = W1;
               en_wr_d    = 1'b1;
               wr_ptr1_d  = skid1_q;
               wr_ptr2_d  = skid2_q;
               skid_vld_d = 1'b0;
               if (en_back_mem) ovr_d = 1'b1;
            end else if (en_back_mem) begin
               // Back-to-back pair goes straight to W1 so writes stay continuous.
               wstate_d  = W1;
               en_wr_d   = 1'b1;
               wr_ptr1_d = adr_ptr1;
               wr_ptr2_d = adr_ptr2;
            end else begin
               wstate_d = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         b_q        <= '0;
         en_rd_q    <= 1'b0;
         en_tw_q    <= 1'b0;
         en_bem_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_ptr_q   <= '0;
         tw_ptr_q   <= '0;
         adr1_q     <= '0;
         adr2_q     <= '0;
         wstate_q   <= W_IDLE;
         en_wr_q    <= 1'b0;
         wr_half_q  <= 1'b0;
         wr_done_q  <= 1'b0;
         ovr_q      <= 1'b0;
         wr_ptr1_q  <= '0;
         wr_ptr2_q  <= '0;
         skid_vld_q <= 1'b0;
         skid1_q    <= '0;
         skid2_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         b_q        <= b_d;
         en_rd_q    <= en_rd_d;
         en_tw_q    <= en_tw_d;
         en_bem_q   <= en_bem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_ptr_q   <= rd_ptr_d;
         tw_ptr_q   <= tw_ptr_d;
         adr1_q     <= adr1_d;
         adr2_q     <= adr2_d;
         wstate_q   <= wstate_d;
         en_wr_q    <= en_wr_d;
         wr_half_q  <= wr_half_d;
         wr_done_q  <= wr_done_d;
         ovr_q      <= ovr_d;
         wr_ptr1_q  <= wr_ptr1_d;
         wr_ptr2_q  <= wr_ptr2_d;
         skid_vld_q <= skid_vld_d;
         skid1_q    <= skid1_d;
         skid2_q    <= skid2_d;
         cnt_q      <= cnt_d;
      end
   end

   assign en_rd         = en_rd_q;
   assign rd_ptr        = rd_ptr_q;
   assign en_tw         = en_tw_q;
   assign tw_ptr        = tw_ptr_q;
   assign adr_ptr1_o    = adr1_q;
   assign adr_ptr2_o    = adr2_q;
   assign en_back_mem_o = en_bem_q;
   assign busy          = busy_q;
   assign done_o        = done_q;
   assign en_wr         = en_wr_q;
   assign wr_ptr1       = wr_ptr1_q;
   assign wr_ptr2       = wr_ptr2_q;
   assign wr_half       = wr_half_q;
   assign wr_done       = wr_done_q;
   assign wr_overrun    = ovr_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl with N=16. Three instances (STAGE 0, 2, 3) share
// all inputs; index 0/1/2 of the output arrays maps to STAGE 0/2/3.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_fft_stage_ctrl;
   localparam int N = 16;
   localparam int SIZE = 4;

   typedef struct {
      int top;
      int bot;
      int tw;
   } pair_t;

   typedef struct {
      int bem;
      int t1;
      int t2;
      int en;
      int half;
      int p1;
      int p2;
      int ovr;
   } wvec_t;

   logic clk = 1'b0;
   logic rst, start, stall, en_back_mem;
   logic [SIZE-1:0] adr_ptr1, adr_ptr2;

   logic            en_rd [3];
   logic [SIZE-1:0] rd_ptr [3];
   logic            en_tw [3];
   logic [SIZE-2:0] tw_ptr [3];
   logic [SIZE-1:0] adr_ptr1_o [3];
   logic [SIZE-1:0] adr_ptr2_o [3];
   logic            en_back_mem_o [3];
   logic            busy [3];
   logic            done_o [3];
   logic            en_wr [3];
   logic [SIZE-1:0] wr_ptr1 [3];
   logic [SIZE-1:0] wr_ptr2 [3];
   logic            wr_half [3];
   logic            wr_done [3];
   logic            wr_overrun [3];

   int n_checks = 0;
   int n_errors = 0;

   pair_t tab [3][8];
   wvec_t wtab [8];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      fft_stage_ctrl #(.N(N), .SIZE(SIZE), .STAGE(gi == 0 ? 0 : gi + 1)) u_dut (
         .clk(clk), .rst(rst), .start(start), .stall(stall),
         .en_rd(en_rd[gi]), .rd_ptr(rd_ptr[gi]), .en_tw(en_tw[gi]), .tw_ptr(tw_ptr[gi]),
         .adr_ptr1_o(adr_ptr1_o[gi]), .adr_ptr2_o(adr_ptr2_o[gi]),
         .en_back_mem_o(en_back_mem_o[gi]), .busy(busy[gi]), .done_o(done_o[gi]),
         .en_back_mem(en_back_mem), .adr_ptr1(adr_ptr1), .adr_ptr2(adr_ptr2),
         .en_wr(en_wr[gi]), .wr_ptr1(wr_ptr1[gi]), .wr_ptr2(wr_ptr2[gi]),
         .wr_half(wr_half[gi]), .wr_done(wr_done[gi]), .wr_overrun(wr_overrun[gi])
      );
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called on a falling edge; start is sampled at the next rising edge (edge 0).
   task automatic start_sweep();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int done_at;
      int nd;
      tab[0] = '{'{0, 8, 0}, '{1, 9, 1}, '{2, 10, 2}, '{3, 11, 3},
                 '{4, 12, 4}, '{5, 13, 5}, '{6, 14, 6}, '{7, 15, 7}};
      tab[1] = '{'{0, 2, 0}, '{1, 3, 4}, '{4, 6, 0}, '{5, 7, 4},
                 '{8, 10, 0}, '{9, 11, 4}, '{12, 14, 0}, '{13, 15, 4}};
      tab[2] = '{'{0, 1, 0}, '{2, 3, 0}, '{4, 5, 0}, '{6, 7, 0},
                 '{8, 9, 0}, '{10, 11, 0}, '{12, 13, 0}, '{14, 15, 0}};
      //          bem t1 t2  en half p1  p2 ovr   (p1 = -1: pointers not checked)
      wtab = '{'{1, 1, 9,   1, 0, 1, 9,   0},
               '{1, 2, 10,  1, 1, 1, 9,   0},
               '{1, 3, 11,  1, 0, 2, 10,  1},
               '{0, 0, 0,   1, 1, 2, 10,  1},
               '{0, 0, 0,   0, 0, -1, -1, 1},
               '{0, 0, 0,   0, 0, -1, -1, 1},
               '{0, 0, 0,   0, 0, -1, -1, 1},
               '{0, 0, 0,   0, 0, -1, -1, 1}};

      rst = 1'b1; start = 1'b0; stall = 1'b0; en_back_mem = 1'b0;
      adr_ptr1 = '0; adr_ptr2 = '0;
      repeat (2) @(negedge clk);
      chk("rst en_rd", int'(en_rd[0]), 0);
      chk("rst rd_ptr", int'(rd_ptr[0]), 0);
      chk("rst busy", int'(busy[0]), 0);
      chk("rst en_wr", int'(en_wr[0]), 0);
      chk("rst wr_overrun", int'(wr_overrun[0]), 0);
      rst = 1'b0;
      @(negedge clk);

      // Plain sweep on all three stages, compared against the address tables.
      start_sweep();
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("s%0d b%0d top en_rd", k, b), int'(en_rd[k]), 1);
            chk($sformatf("s%0d b%0d top rd_ptr", k, b), int'(rd_ptr[k]), tab[k][b].top);
            chk($sformatf("s%0d b%0d top tag", k, b), int'(adr_ptr1_o[k]), tab[k][b].top);
            chk($sformatf("s%0d b%0d top bem", k, b), int'(en_back_mem_o[k]), 0);
            chk($sformatf("s%0d b%0d top en_tw", k, b), int'(en_tw[k]), 0);
         end
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("s%0d b%0d bot en_rd", k, b), int'(en_rd[k]), 1);
            chk($sformatf("s%0d b%0d bot rd_ptr", k, b), int'(rd_ptr[k]), tab[k][b].bot);
            chk($sformatf("s%0d b%0d bot tag", k, b), int'(adr_ptr2_o[k]), tab[k][b].bot);
            chk($sformatf("s%0d b%0d bot en_tw", k, b), int'(en_tw[k]), 1);
            chk($sformatf("s%0d b%0d bot tw_ptr", k, b), int'(tw_ptr[k]), tab[k][b].tw);
            chk($sformatf("s%0d b%0d bot bem", k, b), int'(en_back_mem_o[k]), 1);
         end
      end
      @(negedge clk);
      chk("edge17 done_o", int'(done_o[0]), 1);
      chk("edge17 en_rd", int'(en_rd[0]), 0);
      chk("edge17 rd_ptr", int'(rd_ptr[0]), 0);
      chk("edge17 busy", int'(busy[0]), 1);
      @(negedge clk);
      chk("edge18 busy", int'(busy[0]), 0);
      chk("edge18 done_o", int'(done_o[0]), 0);

      // Stall for edges 6..8, which holds the bottom read of b=2.
      start_sweep();
      done_at = -1;
      for (int e = 1; e <= 25; e++) begin
         stall = (e >= 6 && e <= 8);
         @(negedge clk);
         if (e >= 6 && e <= 8) begin
            chk($sformatf("stall e%0d en_rd", e), int'(en_rd[0]), 0);
            chk($sformatf("stall e%0d bem", e), int'(en_back_mem_o[0]), 0);
            chk($sformatf("stall e%0d busy", e), int'(busy[0]), 1);
         end
         if (e == 9) begin
            chk("stall reissue en_rd", int'(en_rd[0]), 1);
            chk("stall reissue rd_ptr", int'(rd_ptr[0]), 10);
            chk("stall reissue tw_ptr", int'(tw_ptr[0]), 2);
         end
         if (done_o[0] && done_at < 0) done_at = e;
      end
      stall = 1'b0;
      chk("stall done edge", done_at, 20);

      // Reset in the middle of a sweep clears outputs without waiting for a clock.
      start_sweep();
      repeat (5) @(negedge clk);
      chk("pre-rst en_rd", int'(en_rd[0]), 1);
      rst = 1'b1;
      #1;
      chk("mid-rst en_rd", int'(en_rd[0]), 0);
      chk("mid-rst rd_ptr", int'(rd_ptr[0]), 0);
      chk("mid-rst busy", int'(busy[0]), 0);
      chk("mid-rst tag2", int'(adr_ptr2_o[0]), 0);
      @(negedge clk);
      chk("mid-rst done_o", int'(done_o[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      start_sweep();
      @(negedge clk);
      chk("restart rd_ptr top", int'(rd_ptr[0]), 0);
      chk("restart en_rd", int'(en_rd[0]), 1);
      @(negedge clk);
      chk("restart rd_ptr bot", int'(rd_ptr[0]), 8);
      nd = 0;
      while (busy[0] && nd < 40) begin
         @(negedge clk);
         nd++;
      end
      chk("restart busy drop", int'(busy[0]), 0);

      // Pairs every second cycle keep writes continuous; wr_done follows pair 8.
      pulse_rst();
      nd = 0;
      for (int k = 0; k <= 17; k++) begin
         en_back_mem = (k % 2 == 0 && k < 16);
         adr_ptr1 = 4'd3;
         adr_ptr2 = 4'd11;
         @(negedge clk);
         if (wr_done[0]) nd++;
         if (k <= 15) begin
            chk($sformatf("stream k%0d en_wr", k), int'(en_wr[0]), 1);
            chk($sformatf("stream k%0d wr_half", k), int'(wr_half[0]), k % 2);
            chk($sformatf("stream k%0d wr_ptr1", k), int'(wr_ptr1[0]), 3);
            chk($sformatf("stream k%0d wr_ptr2", k), int'(wr_ptr2[0]), 11);
         end
         if (k == 16) begin
            chk("stream wr_done", int'(wr_done[0]), 1);
            chk("stream idle en_wr", int'(en_wr[0]), 0);
         end
      end
      chk("stream wr_done count", nd, 1);
      chk("stream no overrun", int'(wr_overrun[0]), 0);

      // Three consecutive pairs: the second waits in the skid, the third is dropped.
      pulse_rst();
      for (int k = 0; k < 8; k++) begin
         en_back_mem = wtab[k].bem[0];
         adr_ptr1 = SIZE'(wtab[k].t1);
         adr_ptr2 = SIZE'(wtab[k].t2);
         @(negedge clk);
         chk($sformatf("skid k%0d en_wr", k), int'(en_wr[0]), wtab[k].en);
         chk($sformatf("skid k%0d wr_half", k), int'(wr_half[0]), wtab[k].half);
         chk($sformatf("skid k%0d overrun", k), int'(wr_overrun[0]), wtab[k].ovr);
         if (wtab[k].p1 >= 0) begin
            chk($sformatf("skid k%0d wr_ptr1", k), int'(wr_ptr1[0]), wtab[k].p1);
            chk($sformatf("skid k%0d wr_ptr2", k), int'(wr_ptr2[0]), wtab[k].p2);
         end
      end
      en_back_mem = 1'b0;
      pulse_rst();
      chk("overrun cleared by rst", int'(wr_overrun[0]), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
